// File: rtl/axi4l_seq_master_if.sv
// AXI4-Lite bus bundle between the sequence master and a 4-register slave.
// The master modport drives address/data/valid and consumes ready/response.
interface axi4l_seq_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi4l_seq_master.sv
// AXI4-Lite self-test master: writes an incrementing pattern, reads it back, flags mismatches.
// Optional macro AXI4L_SEQ_ERR_CNT_EN adds a saturating ERR_COUNT output.
module axi4l_seq_master #(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_NUM_TRANSACTIONS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = '0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_START_DATA       = 'h1
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               INIT_TXN,
    output logic               TXN_DONE,
    output logic               ERROR,
    output logic               BUSY,
`ifdef AXI4L_SEQ_ERR_CNT_EN
    output logic [7:0]         ERR_COUNT,
`endif
    axi4l_seq_master_if.master m_axi
);

    typedef enum logic [2:0] {
        StIdle, StWrAddrData, StWrResp, StRdAddr, StRdData, StDone
    } state_e;

    localparam logic [3:0] LastIdx = 4'(C_NUM_TRANSACTIONS - 1);

    state_e                          state_q, state_d;
    logic [3:0]                      idx_q, idx_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic                            error_q, error_d;
    logic                            init_q;
    logic                            start_run;
    logic                            fail;
    logic [C_M_AXI_DATA_WIDTH-1:0]   exp_data;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_addr;

    assign start_run = (state_q == StIdle) && INIT_TXN && !init_q;
    assign exp_data  = C_START_DATA + C_M_AXI_DATA_WIDTH'(idx_q);
    assign cur_addr  = C_TARGET_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        fail      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_run) begin
                    error_d   = 1'b0;
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrAddrData;
                end
            end
            StWrAddrData: begin
                // AW and W complete independently; leave once both have been accepted.
                if (!aw_done_q && m_axi.M_AXI_AWREADY) aw_done_d = 1'b1;
                if (!w_done_q && m_axi.M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)             state_d   = StWrResp;
            end
            StWrResp: begin
                if (m_axi.M_AXI_BVALID) begin
                    fail      = (m_axi.M_AXI_BRESP != 2'b00);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StRdAddr;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StWrAddrData;
                    end
                end
            end
            StRdAddr: begin
                if (m_axi.M_AXI_ARREADY) state_d = StRdData;
            end
            StRdData: begin
                if (m_axi.M_AXI_RVALID) begin
                    fail = (m_axi.M_AXI_RRESP != 2'b00) || (m_axi.M_AXI_RDATA != exp_data);
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StRdAddr;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fail) error_d = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
            init_q    <= INIT_TXN;
        end
    end

`ifdef AXI4L_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // One count per failing beat, so a bad RRESP with bad data still counts once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_run)                        err_cnt_d = '0;
        else if (fail && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign ERR_COUNT = err_cnt_q;
`endif

    // All bus outputs decode from flops only, so reset clears them asynchronously.
    assign m_axi.M_AXI_AWADDR  = cur_addr;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = (state_q == StWrAddrData) && !aw_done_q;
    assign m_axi.M_AXI_WDATA   = exp_data;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WVALID  = (state_q == StWrAddrData) && !w_done_q;
    assign m_axi.M_AXI_BREADY  = (state_q == StWrResp);
    assign m_axi.M_AXI_ARADDR  = cur_addr;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = (state_q == StRdAddr);
    assign m_axi.M_AXI_RREADY  = (state_q == StRdData);

    assign TXN_DONE = (state_q == StDone);
    assign BUSY     = (state_q != StIdle) && (state_q != StDone);
    assign ERROR    = error_q;

endmodule

// File: tb/tb_axi4l_seq_master.sv
// Randomized bench: behavioural 4-register slave with delay/error injection,
// write/read scoreboard and a protocol monitor for the sequence master.
module tb_axi4l_seq_master;

    localparam int unsigned NTX   = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] START = 32'h0000_0001;

    logic clk;
    logic rst_n;
    logic init_txn;
    logic txn_done;
    logic error;
    logic busy;
`ifdef AXI4L_SEQ_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    axi4l_seq_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4l_seq_master dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .INIT_TXN  (init_txn),
        .TXN_DONE  (txn_done),
        .ERROR     (error),
        .BUSY      (busy),
`ifdef AXI4L_SEQ_ERR_CNT_EN
        .ERR_COUNT (err_count),
`endif
        .m_axi     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Slave configuration, set by the stimulus before each run.
    int        aw_min, aw_max, w_min, w_max, b_max, ar_max, r_max;
    bit [15:0] bad_b_mask, bad_rresp_mask, bad_rdata_mask;

    // Slave state and scoreboard logs.
    logic [31:0] mem [16];
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];
    logic [31:0] rd_a [$];
    int          slv_wr_idx, slv_rd_idx;
    bit          aw_have, aw_fire, w_have, w_fire, b_busy, b_fire, b_bad;
    bit          ar_have, ar_fire, r_busy, r_fire, r_bad_resp, r_bad_data;
    int          aw_cnt, aw_dly, w_cnt, w_dly, b_cnt, b_dly;
    int          ar_cnt, ar_dly, r_cnt, r_dly;
    logic [31:0] aw_cap, w_cap, ar_cap;

    int proto_err = 0;
    int done_cnt  = 0;

    task automatic slave_clear();
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RVALID  = 1'b0;
        bus.M_AXI_RRESP   = 2'b00;
        bus.M_AXI_RDATA   = '0;
        {aw_have, aw_fire, w_have, w_fire, b_busy, b_fire} = '0;
        {ar_have, ar_fire, r_busy, r_fire} = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_dly = -1; w_dly = -1; ar_dly = -1;
    endtask

    // Slave: every decision is made at negedge so inputs are stable across the posedge.
    initial begin
        slave_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
            end else begin
                if (b_fire) begin
                    bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00; b_busy = 0; b_fire = 0;
                end else if (b_busy) begin
                    if (b_cnt >= b_dly) begin
                        bus.M_AXI_BVALID = 1'b1;
                        bus.M_AXI_BRESP  = b_bad ? 2'b10 : 2'b00;
                        b_fire = bus.M_AXI_BREADY;
                    end else b_cnt++;
                end
                if (aw_have && w_have) begin
                    mem[aw_cap[5:2]] = w_cap;
                    wr_a.push_back(aw_cap);
                    wr_d.push_back(w_cap);
                    b_bad = (slv_wr_idx < 16) ? bad_b_mask[slv_wr_idx] : 1'b0;
                    slv_wr_idx++;
                    b_busy = 1; b_cnt = 0; b_dly = int'($urandom_range(b_max, 0));
                    aw_have = 0; w_have = 0;
                end
                if (aw_fire) begin
                    bus.M_AXI_AWREADY = 1'b0; aw_fire = 0;
                end else if (bus.M_AXI_AWVALID && !aw_have) begin
                    if (aw_dly < 0) aw_dly = int'($urandom_range(aw_max, aw_min));
                    if (aw_cnt >= aw_dly) begin
                        bus.M_AXI_AWREADY = 1'b1; aw_fire = 1; aw_have = 1;
                        aw_cap = bus.M_AXI_AWADDR; aw_cnt = 0; aw_dly = -1;
                    end else aw_cnt++;
                end
                if (w_fire) begin
                    bus.M_AXI_WREADY = 1'b0; w_fire = 0;
                end else if (bus.M_AXI_WVALID && !w_have) begin
                    if (w_dly < 0) w_dly = int'($urandom_range(w_max, w_min));
                    if (w_cnt >= w_dly) begin
                        bus.M_AXI_WREADY = 1'b1; w_fire = 1; w_have = 1;
                        w_cap = bus.M_AXI_WDATA; w_cnt = 0; w_dly = -1;
                    end else w_cnt++;
                end
                if (r_fire) begin
                    bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00; r_busy = 0; r_fire = 0;
                end else if (r_busy) begin
                    if (r_cnt >= r_dly) begin
                        bus.M_AXI_RVALID = 1'b1;
                        bus.M_AXI_RRESP  = r_bad_resp ? 2'b10 : 2'b00;
                        bus.M_AXI_RDATA  = mem[ar_cap[5:2]] ^ (r_bad_data ? 32'h6 : 32'h0);
                        r_fire = bus.M_AXI_RREADY;
                    end else r_cnt++;
                end
                if (ar_have) begin
                    rd_a.push_back(ar_cap);
                    r_bad_resp = (slv_rd_idx < 16) ? bad_rresp_mask[slv_rd_idx] : 1'b0;
                    r_bad_data = (slv_rd_idx < 16) ? bad_rdata_mask[slv_rd_idx] : 1'b0;
                    slv_rd_idx++;
                    r_busy = 1; r_cnt = 0; r_dly = int'($urandom_range(r_max, 0));
                    ar_have = 0;
                end
                if (ar_fire) begin
                    bus.M_AXI_ARREADY = 1'b0; ar_fire = 0;
                end else if (bus.M_AXI_ARVALID && !ar_have && !r_busy) begin
                    if (ar_dly < 0) ar_dly = int'($urandom_range(ar_max, 0));
                    if (ar_cnt >= ar_dly) begin
                        bus.M_AXI_ARREADY = 1'b1; ar_fire = 1; ar_have = 1;
                        ar_cap = bus.M_AXI_ARADDR; ar_cnt = 0; ar_dly = -1;
                    end else ar_cnt++;
                end
            end
        end
    end

    // Protocol monitor: VALID stability, drop after handshake, no write/read overlap.
    bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
            end else begin
                if (p_awv && !p_awr && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR !== p_awaddr))
                    proto_err++;
                if (p_wv && !p_wr && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA !== p_wdata))
                    proto_err++;
                if (p_arv && !p_arr && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR !== p_araddr))
                    proto_err++;
                if ((p_awv && p_awr && bus.M_AXI_AWVALID) || (p_wv && p_wr && bus.M_AXI_WVALID) ||
                    (p_arv && p_arr && bus.M_AXI_ARVALID))
                    proto_err++;
                if ((bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY) &&
                    (bus.M_AXI_ARVALID || bus.M_AXI_RREADY))
                    proto_err++;
                if (bus.M_AXI_AWPROT != 3'b000 || bus.M_AXI_ARPROT != 3'b000 ||
                    bus.M_AXI_WSTRB != 4'hF)
                    proto_err++;
                if (txn_done) begin
                    done_cnt++;
                    if (busy) proto_err++;
                end
                p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
                p_wv  = bus.M_AXI_WVALID;  p_wr  = bus.M_AXI_WREADY;  p_wdata  = bus.M_AXI_WDATA;
                p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
            end
        end
    end

    task automatic set_cfg(input int awn, input int awx, input int wn, input int wx,
                           input int bx, input int arx, input int rx);
        aw_min = awn; aw_max = awx; w_min = wn; w_max = wx;
        b_max = bx; ar_max = arx; r_max = rx;
        bad_b_mask = '0; bad_rresp_mask = '0; bad_rdata_mask = '0;
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        slv_wr_idx = 0; slv_rd_idx = 0;
        done_cnt = 0; proto_err = 0;
    endtask

    // One complete run: start pulse, optional INIT_TXN toggling, then scoreboard checks.
    task automatic do_run(input string tag, input bit toggle);
        bit got_busy;
        bit finished;
        int exp_cnt;
        clear_logs();
        @(negedge clk);
        init_txn = 1'b1;
        got_busy = 0;
        for (int i = 0; i < 10 && !got_busy; i++) begin
            @(negedge clk);
            if (busy) got_busy = 1;
        end
        check_eq({tag, "_busy_rise"}, 32'(got_busy), 32'd1);
        check_eq({tag, "_err_clr"}, 32'(error), 32'd0);
`ifdef AXI4L_SEQ_ERR_CNT_EN
        check_eq({tag, "_cnt_clr"}, 32'(err_count), 32'd0);
`endif
        init_txn = 1'b0;
        if (toggle) begin
            repeat (3) @(negedge clk);
            init_txn = 1'b1; @(negedge clk); init_txn = 1'b0;
            repeat (4) @(negedge clk);
            init_txn = 1'b1; @(negedge clk); init_txn = 1'b0;
        end
        finished = 0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(negedge clk);
            if (done_cnt > 0) finished = 1;
        end
        check_eq({tag, "_finished"}, 32'(finished), 32'd1);
        repeat (20) @(negedge clk);

        exp_cnt = 0;
        for (int i = 0; i < NTX; i++) begin
            if (bad_b_mask[i]) exp_cnt++;
            if (bad_rresp_mask[i] || bad_rdata_mask[i]) exp_cnt++;
        end
        check_eq({tag, "_nwr"}, 32'(wr_a.size()), NTX);
        check_eq({tag, "_nrd"}, 32'(rd_a.size()), NTX);
        for (int i = 0; i < NTX; i++) begin
            if (i < wr_a.size()) begin
                check_eq($sformatf("%s_waddr%0d", tag, i), wr_a[i], BASE + 32'(4 * i));
                check_eq($sformatf("%s_wdata%0d", tag, i), wr_d[i], START + 32'(i));
            end
            if (i < rd_a.size())
                check_eq($sformatf("%s_raddr%0d", tag, i), rd_a[i], BASE + 32'(4 * i));
        end
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_error"}, 32'(error), 32'(exp_cnt != 0));
`ifdef AXI4L_SEQ_ERR_CNT_EN
        check_eq({tag, "_err_count"}, 32'(err_count), 32'(exp_cnt > 255 ? 255 : exp_cnt));
`endif
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_eq({tag, "_proto"}, 32'(proto_err), 32'd0);
    endtask

    task automatic reset_mid_run();
        bit hit;
        clear_logs();
        set_cfg(0, 1, 1, 2, 0, 0, 0);
        bad_b_mask = 16'h0001;
        @(negedge clk);
        init_txn = 1'b1;
        @(negedge clk);
        init_txn = 1'b0;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (wr_a.size() == 2 && bus.M_AXI_WVALID && bus.M_AXI_WREADY) hit = 1;
        end
        check_eq("rst_hit_w3", 32'(hit), 32'd1);
        check_eq("rst_err_before", 32'(error), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_outputs_zero",
                 {24'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                  bus.M_AXI_BREADY, bus.M_AXI_RREADY, busy, error, txn_done}, 32'd0);
`ifdef AXI4L_SEQ_ERR_CNT_EN
        check_eq("rst_err_count", 32'(err_count), 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_no_resume", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        init_txn = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_state",
                 {24'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                  bus.M_AXI_BREADY, bus.M_AXI_RREADY, busy, error, txn_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_cfg(0, 0, 0, 0, 0, 0, 0);
        do_run("zero_wait", 1'b0);

        set_cfg(0, 0, 3, 3, 5, 0, 5);
        do_run("w_late", 1'b0);

        set_cfg(0, 2, 0, 2, 3, 2, 3);
        bad_rdata_mask = 16'h0004;
        do_run("rdata_bad", 1'b0);

        set_cfg(0, 0, 0, 0, 2, 0, 2);
        bad_b_mask = 16'h0001;
        do_run("bresp_bad", 1'b0);

        set_cfg(2, 5, 2, 5, 5, 5, 5);
        do_run("toggle", 1'b1);

        reset_mid_run();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        do_run("after_rst", 1'b0);

        for (int r = 0; r < 8; r++) begin
            set_cfg(0, int'($urandom_range(4, 0)), 0, int'($urandom_range(4, 0)),
                    int'($urandom_range(5, 0)), int'($urandom_range(4, 0)),
                    int'($urandom_range(5, 0)));
            if ($urandom_range(1, 0) == 1) begin
                bad_b_mask     = 16'($urandom) & 16'h000F & 16'($urandom);
                bad_rresp_mask = 16'($urandom) & 16'h000F & 16'($urandom);
                bad_rdata_mask = 16'($urandom) & 16'h000F & 16'($urandom);
            end
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
